// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset-release controller.
// Holds the power-sequencer state codes and the per-channel FSM encoding.
package rst_seq_pkg;

    localparam int ST_START          = 0;
    localparam int ST_SBY            = 1;
    localparam int ST_SBY_END        = 2;
    localparam int ST_PS_ON          = 3;
    localparam int ST_WORK_PWR_GOOD  = 4;
    localparam int ST_ALL_PWR_GOOD   = 5;
    localparam int ST_T5_RESET       = 6;
    localparam int ST_T5_RESET_END   = 7;
    localparam int ST_PCIE_RESET_END = 8;
    localparam int ST_ICH_DC_OK      = 9;
    localparam int ST_ICH_PWR_GOOD   = 10;
    localparam int ST_CPU_DC_OK      = 11;
    localparam int ST_END            = 12;

    typedef enum logic [1:0] {
        CH_HOLD    = 2'd0,
        CH_STRETCH = 2'd1,
        CH_RUN     = 2'd2,
        CH_SWRST   = 2'd3
    } ch_state_t;

    // A zero-length pulse still needs a one-bit counter to keep ports legal.
    function automatic int cnt_width(input int pulse_cyc);
        int w;
        w = $clog2(pulse_cyc + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Sequencer-facing bundle of the reset-release controller.
// master drives state/requests, slave (the controller) drives the resets.
interface rst_seq_ctrl_if #(
    parameter int N_CH    = 4,
    parameter int STATE_W = 4
);
    logic [STATE_W-1:0] i_ctrl_state;
    logic               i_UI_rst_n;
    logic [N_CH-1:0]    i_reg_rst;
    logic [N_CH-1:0]    o_rst_n;
    logic [N_CH-1:0]    o_sw_busy;

    modport master (
        output i_ctrl_state,
        output i_UI_rst_n,
        output i_reg_rst,
        input  o_rst_n,
        input  o_sw_busy
    );

    modport slave (
        input  i_ctrl_state,
        input  i_UI_rst_n,
        input  i_reg_rst,
        output o_rst_n,
        output o_sw_busy
    );
endinterface

// File: rtl/rst_seq_ch.sv
// One reset channel: request synchroniser, edge detect, release FSM and
// assertion-width counter. Outputs are registered from the next state.
module rst_seq_ch
    import rst_seq_pkg::*;
#(
    parameter int                 STATE_W   = 4,
    parameter logic [STATE_W-1:0] REL_STATE = 4'h9,
    parameter logic [STATE_W-1:0] SBY_STATE = 4'h1,
    parameter logic [STATE_W-1:0] END_STATE = 4'hC,
    parameter int                 PULSE_CYC = 32,
    parameter int                 CNT_W     = 6
) (
    input  logic               i_clk_32k,
    input  logic               i_rst_n,
    input  logic [STATE_W-1:0] i_ctrl_state,
    input  logic               i_UI_rst_n,
    input  logic               i_reg_rst,
    output logic               o_rst_n,
    output logic               o_sw_busy
);

    localparam logic [CNT_W-1:0] LOAD = (PULSE_CYC > 0) ? CNT_W'(PULSE_CYC - 1) : '0;
    localparam ch_state_t STRETCH_OR_RUN = (PULSE_CYC > 0) ? CH_STRETCH : CH_RUN;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    ch_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rst_n;
    logic             r_sw_busy;

    ch_state_t        w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_rst_n_next;
    logic             w_sw_busy_next;
    logic             w_rel_ok;
    logic             w_req_edge;

    always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_reg_rst;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_req_edge = r_sync2 & ~r_sync3;
    assign w_rel_ok   = (i_ctrl_state != SBY_STATE) && (i_ctrl_state >= REL_STATE);

    always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= CH_HOLD;
            r_cnt     <= '0;
            r_rst_n   <= 1'b0;
            r_sw_busy <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_rst_n   <= w_rst_n_next;
            r_sw_busy <= w_sw_busy_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (!w_rel_ok) begin
            w_state_next = CH_HOLD;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                CH_HOLD: begin
                    w_state_next = STRETCH_OR_RUN;
                    w_cnt_next   = LOAD;
                end
                CH_STRETCH: begin
                    if (r_cnt == '0) begin
                        w_state_next = CH_RUN;
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
                CH_RUN: begin
                    if ((i_ctrl_state == END_STATE) && i_UI_rst_n && w_req_edge) begin
                        w_state_next = CH_SWRST;
                        w_cnt_next   = LOAD;
                    end
                end
                CH_SWRST: begin
                    // Counter saturates at zero; a held request keeps the channel here.
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end else if (!r_sync2) begin
                        w_state_next = STRETCH_OR_RUN;
                        w_cnt_next   = LOAD;
                    end
                end
                default: begin
                    w_state_next = CH_HOLD;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_rst_n_next   = (w_state_next == CH_RUN);
        w_sw_busy_next = (w_state_next == CH_SWRST);
    end

    assign o_rst_n   = r_rst_n;
    assign o_sw_busy = r_sw_busy;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Multi-channel reset-release controller on the 32 kHz sequencing clock.
// Each channel has its own release threshold sliced from REL_STATE.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int                         N_CH      = 4,
    parameter int                         STATE_W   = 4,
    parameter logic [N_CH*STATE_W-1:0]    REL_STATE = {4'hB, 4'hA, 4'h9, 4'h9},
    parameter logic [STATE_W-1:0]         SBY_STATE = STATE_W'(ST_SBY),
    parameter logic [STATE_W-1:0]         END_STATE = STATE_W'(ST_END),
    parameter int                         PULSE_CYC = 32,
    parameter int                         CNT_W     = cnt_width(PULSE_CYC)
) (
    input  logic           i_clk_32k,
    input  logic           i_rst_n,
    rst_seq_ctrl_if.slave  bus
);

    logic [N_CH-1:0] w_rst_n;
    logic [N_CH-1:0] w_sw_busy;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            rst_seq_ch #(
                .STATE_W   (STATE_W),
                .REL_STATE (REL_STATE[gi*STATE_W +: STATE_W]),
                .SBY_STATE (SBY_STATE),
                .END_STATE (END_STATE),
                .PULSE_CYC (PULSE_CYC),
                .CNT_W     (CNT_W)
            ) u_ch (
                .i_clk_32k    (i_clk_32k),
                .i_rst_n      (i_rst_n),
                .i_ctrl_state (bus.i_ctrl_state),
                .i_UI_rst_n   (bus.i_UI_rst_n),
                .i_reg_rst    (bus.i_reg_rst[gi]),
                .o_rst_n      (w_rst_n[gi]),
                .o_sw_busy    (w_sw_busy[gi])
            );
        end
    endgenerate

    assign bus.o_rst_n   = w_rst_n;
    assign bus.o_sw_busy = w_sw_busy;

endmodule
